// File: rtl/compare_serial_if.sv
// Operand/result bundle for the serial magnitude comparator; the master side drives the
// operands and start, and the slave side returns status and the result flags.
interface compare_serial_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             signed_mode;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic             AEB;
   logic             ASB;
   logic             AGB;

   modport master (
      output start, signed_mode, A, B,
      input  busy, done, AEB, ASB, AGB
   );

   modport slave (
      input  start, signed_mode, A, B,
      output busy, done, AEB, ASB, AGB
   );
endinterface

// File: rtl/compare_serial.sv
// Multi-cycle magnitude comparator: CHUNK bits per clock, MSB-first, early exit on first differing chunk.
// Latency 1..NCHUNK edges after start; start is ignored while busy, and flags hold until the next decision.
module compare_serial #(
   parameter int WIDTH     = 8,
   parameter int CHUNK     = 2,
   parameter bit SIGNED_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   compare_serial_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("compare_serial: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state, state_n;
   logic [WIDTH-1:0]  a_q, a_n, b_q, b_n;
   logic [WIDTH-1:0]  sign_flip;
   logic [IDXW-1:0]   idx, idx_n;
   logic [2:0]        flags, flags_n;   // {AGB, ASB, AEB}
   logic              done_q, done_n;
   logic [CHUNK-1:0]  ca, cb;

   // Flipping the sign bit maps two's-complement order onto unsigned order.
   assign sign_flip = {(bus.signed_mode && SIGNED_EN), {(WIDTH-1){1'b0}}};

   assign ca = a_q[idx*CHUNK +: CHUNK];
   assign cb = b_q[idx*CHUNK +: CHUNK];

   always_comb begin
      state_n = state;
      a_n     = a_q;
      b_n     = b_q;
      idx_n   = idx;
      flags_n = flags;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = RUN;
               a_n     = bus.A ^ sign_flip;
               b_n     = bus.B ^ sign_flip;
               idx_n   = IDX_LAST;
            end
         end
         RUN: begin
            if (ca != cb) begin
               flags_n = {(ca > cb), (ca < cb), 1'b0};
               done_n  = 1'b1;
               state_n = IDLE;
            end else if (idx == '0) begin
               flags_n = 3'b001;
               done_n  = 1'b1;
               state_n = IDLE;
            end else begin
               idx_n = idx - IDXW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         idx    <= '0;
         flags  <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         a_q    <= a_n;
         b_q    <= b_n;
         idx    <= idx_n;
         flags  <= flags_n;
         done_q <= done_n;
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = done_q;
   assign bus.AGB  = flags[2];
   assign bus.ASB  = flags[1];
   assign bus.AEB  = flags[0];
endmodule

// File: tb/tb_compare_serial.sv
// Scoreboard bench for compare_serial: an 8-bit/2-bit instance and a 12-bit/3-bit instance.
module tb_compare_serial;
   logic clk;
   logic rst;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [2:0] f;    // {AGB, ASB, AEB}
      int         c;    // cycle count at which done must be seen
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sg;
      logic [2:0]  f;
      int          k;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];

   compare_serial_if #(.WIDTH(8))  if0();
   compare_serial_if #(.WIDTH(12)) if1();

   compare_serial #(.WIDTH(8),  .CHUNK(2), .SIGNED_EN(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   compare_serial #(.WIDTH(12), .CHUNK(3), .SIGNED_EN(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Reference: integer compare for flags; decision edge from the highest differing bit.
   function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input int w, input int ch, input logic sg,
                                        output int k);
      int          va, vb;
      logic [15:0] d;
      va = int'(a);
      vb = int'(b);
      if (sg && a[w-1]) va = va - (1 << w);
      if (sg && b[w-1]) vb = vb - (1 << w);
      d = a ^ b;
      k = w / ch;
      for (int i = 0; i < w; i++)
         if (d[i]) k = w / ch - i / ch;
      if (va > vb)      model = 3'b100;
      else if (va < vb) model = 3'b010;
      else              model = 3'b001;
   endfunction

   task automatic mon(input int sel, input logic d, input logic bz, input logic [2:0] fl);
      exp_t e;
      if (d) begin
         checks++;
         if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            errors++;
            $display("FAIL dut%0d unexpected_done: got done=1 at cycle %0d, required no done", sel, cyc);
         end else begin
            e = (sel == 0) ? q0.pop_front() : q1.pop_front();
            if (fl !== e.f || cyc != e.c || bz !== 1'b0) begin
               errors++;
               $display("FAIL dut%0d result: got flags=%b cycle=%0d busy=%b, required flags=%b cycle=%0d busy=0",
                        sel, fl, cyc, bz, e.f, e.c);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, if0.done, if0.busy, {if0.AGB, if0.ASB, if0.AEB});
         mon(1, if1.done, if1.busy, {if1.AGB, if1.ASB, if1.AEB});
      end
   end

   task automatic check_idle(input int sel, input string nm);
      logic [4:0] got;
      got = (sel == 0) ? {if0.busy, if0.done, if0.AGB, if0.ASB, if0.AEB}
                       : {if1.busy, if1.done, if1.AGB, if1.ASB, if1.AEB};
      checks++;
      if (got !== 5'b00000) begin
         errors++;
         $display("FAIL dut%0d %s: got busy,done,AGB,ASB,AEB=%b, required 00000", sel, nm, got);
      end
   endtask

   // Entered and left at #1 after a rising edge; waits for idle, then launches one compare.
   task automatic issue(input int sel, input logic [15:0] a, input logic [15:0] b,
                        input logic sg, input logic [2:0] f, input int k);
      int   t;
      exp_t e;
      t = 0;
      while ((sel == 0) ? if0.busy : if1.busy) begin
         if (t > 100) begin
            checks++;
            errors++;
            $display("FAIL dut%0d idle_wait: busy still 1 after %0d cycles, required 0", sel, t);
            return;
         end
         @(posedge clk); #1;
         t++;
      end
      if (sel == 0) begin
         if0.A = a[7:0]; if0.B = b[7:0]; if0.signed_mode = sg; if0.start = 1'b1;
      end else begin
         if1.A = a[11:0]; if1.B = b[11:0]; if1.signed_mode = sg; if1.start = 1'b1;
      end
      @(posedge clk); #1;
      if0.start = 1'b0;
      if1.start = 1'b0;
      checks++;
      if (((sel == 0) ? if0.busy : if1.busy) !== 1'b1) begin
         errors++;
         $display("FAIL dut%0d accept_busy: got busy=0 after start, required 1", sel);
      end
      e.f = f;
      e.c = cyc + k;
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
   endtask

   task automatic rnd(input int sel);
      logic [15:0] a, b;
      logic        sg;
      logic [2:0]  f;
      int          k, w, ch;
      w  = (sel == 0) ? 8 : 12;
      ch = (sel == 0) ? 2 : 3;
      a  = 16'($urandom) & ((16'd1 << w) - 16'd1);
      case ($urandom_range(0, 3))
         0:       b = a;
         1:       b = a ^ (16'd1 << $urandom_range(0, w - 1));
         default: b = 16'($urandom) & ((16'd1 << w) - 16'd1);
      endcase
      sg = 1'($urandom_range(0, 1));
      f  = model(a, b, w, ch, sg, k);
      issue(sel, a, b, sg, f, k);
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (q0.size() != 0 || q1.size() != 0) begin
         if (t > 200) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d/%0d results outstanding, required 0/0", q0.size(), q1.size());
            return;
         end
         @(posedge clk); #1;
         t++;
      end
   endtask

   vec_t dir0 [9] = '{
      '{16'h80,  16'h7F,  1'b0, 3'b100, 1},
      '{16'h5A,  16'h5A,  1'b0, 3'b001, 4},
      '{16'h34,  16'h35,  1'b0, 3'b010, 4},
      '{16'h80,  16'h01,  1'b1, 3'b010, 1},
      '{16'h80,  16'h01,  1'b0, 3'b100, 1},
      '{16'hFF,  16'hFE,  1'b1, 3'b100, 4},
      '{16'h7F,  16'h80,  1'b1, 3'b100, 1},
      '{16'h0C,  16'h08,  1'b0, 3'b100, 3},
      '{16'h00,  16'h00,  1'b1, 3'b001, 4}
   };

   vec_t dir1 [4] = '{
      '{16'h800, 16'h7FF, 1'b1, 3'b010, 1},
      '{16'h800, 16'h7FF, 1'b0, 3'b100, 1},
      '{16'h123, 16'h124, 1'b0, 3'b010, 4},
      '{16'hABC, 16'hABC, 1'b1, 3'b001, 4}
   };

   initial begin
      rst = 1'b1;
      if0.start = 1'b0; if0.signed_mode = 1'b0; if0.A = '0; if0.B = '0;
      if1.start = 1'b0; if1.signed_mode = 1'b0; if1.A = '0; if1.B = '0;
      repeat (2) @(posedge clk);
      #1;
      check_idle(0, "reset");
      check_idle(1, "reset");
      rst = 1'b0;

      foreach (dir0[i]) issue(0, dir0[i].a, dir0[i].b, dir0[i].sg, dir0[i].f, dir0[i].k);
      foreach (dir1[i]) issue(1, dir1[i].a, dir1[i].b, dir1[i].sg, dir1[i].f, dir1[i].k);
      drain();

      // start during busy with new operands must not disturb the run in progress
      issue(0, 16'h10, 16'h20, 1'b0, 3'b010, 2);
      if0.A = 8'hFF; if0.B = 8'h00; if0.start = 1'b1;
      @(posedge clk); #1;
      if0.start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (if0.done !== 1'b1 || if0.busy !== 1'b0) begin
         errors++;
         $display("FAIL dut0 done_cycle: got done=%b busy=%b, required done=1 busy=0", if0.done, if0.busy);
      end
      issue(0, 16'h01, 16'h02, 1'b0, 3'b010, 4);
      drain();

      // reset at E2 of a 4-chunk run aborts it with no done pulse
      if0.A = 8'h00; if0.B = 8'h00; if0.signed_mode = 1'b0; if0.start = 1'b1;
      @(posedge clk); #1;
      if0.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_idle(0, "midrun_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check_idle(0, "after_abort");

      for (int i = 0; i < 25; i++) begin
         rnd(0);
         rnd(1);
      end
      drain();
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
